// File: rtl/arb_rr.sv
// Round-robin arbiter with a registered one-hot grant and valid/ready handshake.
// Define ARB_RR_LOCK_EN to add the lck input, which re-grants the same index on transfer.
module arb_rr #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] gnt,
   output logic             vld,
   input  logic             rdy
`ifdef ARB_RR_LOCK_EN
   ,
   input  logic             lck
`endif
);

   localparam int WIDTH_LOG = $clog2(WIDTH);

   logic [WIDTH-1:0]     gnt_q, gnt_d;
   logic                 vld_q, vld_d;
   logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
   logic [WIDTH_LOG-1:0] gnt_idx;
   logic                 xfer;
   logic                 hold_lock;
   logic                 found;

   assign xfer = vld_q & rdy;

`ifdef ARB_RR_LOCK_EN
   assign hold_lock = xfer & lck & (|(req & gnt_q));
`else
   assign hold_lock = 1'b0;
`endif

   // One-hot to binary; gnt_q is never multi-hot so the last match is the only match.
   always_comb begin
      gnt_idx = '0;
      for (int j = 0; j < WIDTH; j++) begin
         if (gnt_q[j]) gnt_idx = WIDTH_LOG'(j);
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
      gnt_d = gnt_q;
      vld_d = vld_q;
      ptr_d = ptr_q;
      found = 1'b0;
      if (!vld_q || (xfer && !hold_lock)) begin
         if (xfer) ptr_d = gnt_idx;
         gnt_d = '0;
         // Two passes give the order ptr+1 .. WIDTH-1, then 0 .. ptr.
         for (int j = 0; j < WIDTH; j++) begin
            if (!found && req[j] && (j > int'(ptr_d))) begin
               gnt_d[j] = 1'b1;
               found    = 1'b1;
            end
         end
         for (int j = 0; j < WIDTH; j++) begin
            if (!found && req[j] && (j <= int'(ptr_d))) begin
               gnt_d[j] = 1'b1;
               found    = 1'b1;
            end
         end
         vld_d = found;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q <= '0;
         vld_q <= 1'b0;
         ptr_q <= WIDTH_LOG'(WIDTH - 1);
      end else begin
         gnt_q <= gnt_d;
         vld_q <= vld_d;
         ptr_q <= ptr_d;
      end
   end

   assign gnt = gnt_q;
   assign vld = vld_q;

endmodule

// File: tb/tb_arb_rr.sv
// Scoreboard bench for arb_rr (WIDTH=4): directed scenarios with hand-computed
// grants, then a random run checked against a reference model plus fairness.
module tb_arb_rr;

   localparam int W = 4;
`ifdef ARB_RR_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] gnt;
      logic         vld;
      string        name;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [W-1:0] req;
   logic [W-1:0] gnt;
   logic         vld;
   logic         rdy;
`ifdef ARB_RR_LOCK_EN
   logic         lck;
`endif

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   rand_phase = 1'b0;

   // Reference model state.
   int m_ptr  = W - 1;
   int m_gidx = -1;

   arb_rr #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt),
      .vld (vld),
      .rdy (rdy)
`ifdef ARB_RR_LOCK_EN
      ,
      .lck (lck)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   function automatic int m_pick(input logic [W-1:0] r, input int p);
      for (int k = 1; k <= W; k++) begin
         int i;
         i = (p + k) % W;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic m_step(input logic rst_v, input logic [W-1:0] r, input logic rdy_v, input logic lck_v);
      if (rst_v) begin
         m_gidx = -1;
         m_ptr  = W - 1;
      end else if (m_gidx < 0 || rdy_v) begin
         if (!(m_gidx >= 0 && LOCK_EN && lck_v && r[m_gidx])) begin
            if (m_gidx >= 0) m_ptr = m_gidx;
            m_gidx = m_pick(r, m_ptr);
         end
      end
   endtask

   // Apply one cycle of stimulus and queue the grant expected after the next edge.
   task automatic drive(input string nm, input logic rst_v, input logic [W-1:0] r,
                        input logic rdy_v, input logic lck_v,
                        input logic [W-1:0] eg, input logic ev);
      exp_t e;
      @(negedge clk);
      rst = rst_v;
      req = r;
      rdy = rdy_v;
`ifdef ARB_RR_LOCK_EN
      lck = lck_v;
`endif
      m_step(rst_v, r, rdy_v, lck_v);
      e.gnt  = eg;
      e.vld  = ev;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: pops one expectation per edge and checks the invariants.
   initial begin : monitor
      exp_t         e;
      int           waitc[W];
      logic [W-1:0] prev_gnt = '0;
      logic         prev_vld = 1'b0;
      int           worst;
      foreach (waitc[i]) waitc[i] = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, " gnt"}, 32'(gnt), 32'(e.gnt));
            check({e.name, " vld"}, 32'(vld), 32'(e.vld));
            check({e.name, " onehot"}, 32'($countones(gnt) <= 1), 32'd1);
            check({e.name, " vld_eq_or"}, 32'(vld), 32'(|gnt));
         end
         if (rand_phase) begin
            for (int i = 0; i < W; i++) if (!req[i]) waitc[i] = 0;
            if (prev_vld && rdy) begin
               worst = 0;
               for (int i = 0; i < W; i++) begin
                  if (prev_gnt[i]) waitc[i] = 0;
                  else if (req[i]) waitc[i]++;
                  if (waitc[i] > worst) worst = waitc[i];
               end
               check("fairness_ok", 32'(worst <= W), 32'd1);
            end
         end
         prev_gnt = gnt;
         prev_vld = vld;
      end
   end

   initial begin : stimulus
      logic [W-1:0] r;
      logic         rd;
      rst = 1'b1;
      req = '0;
      rdy = 1'b0;
`ifdef ARB_RR_LOCK_EN
      lck = 1'b0;
`endif
      // Reset state, regardless of inputs.
      drive("reset0", 1'b1, 4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0);
      drive("reset1", 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0);
      // Reset release: full rotation starting at index 0, no bubbles.
      drive("rr0", 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);
      drive("rr1", 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1);
      drive("rr2", 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1);
      drive("rr3", 1'b0, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1);
      drive("rr4", 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1);
      drive("rr5", 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1);
      // Stall: grant holds while req changes.
      for (int k = 0; k < 5; k++) drive("stall", 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0010, 1'b1);
      drive("stall_rel", 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1);
      // Empty then wrap from ptr=3 to index 0.
      drive("to_idx3", 1'b0, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1);
      drive("empty0", 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
      drive("empty1", 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0);
      drive("wrap", 1'b0, 4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1);
      // Reset during a stalled grant.
      drive("to_idx2", 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1);
      drive("hold2", 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1);
      drive("rst_mid", 1'b1, 4'b0101, 1'b0, 1'b0, 4'b0000, 1'b0);
      drive("post_rst", 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0001, 1'b1);
      drive("post_rst_hold", 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0001, 1'b1);
`ifdef ARB_RR_LOCK_EN
      // Lock: same index re-granted, pointer frozen, then normal advance.
      drive("lk_pre", 1'b0, 4'b0110, 1'b1, 1'b0, 4'b0010, 1'b1);
      for (int k = 0; k < 3; k++) drive("lk_hold", 1'b0, 4'b0110, 1'b1, 1'b1, 4'b0010, 1'b1);
      drive("lk_rel", 1'b0, 4'b0110, 1'b1, 1'b0, 4'b0100, 1'b1);
      drive("lk_noreq", 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1);
`endif
      // Random run against the reference model with sticky requests.
      drive("rand_rst", 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
      rand_phase = 1'b1;
      r = '0;
      for (int n = 0; n < 10000; n++) begin
         for (int b = 0; b < W; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
         rd = ($urandom_range(0, 3) != 0);
         m_step(1'b0, r, rd, 1'b0);
         begin
            exp_t e;
            @(negedge clk);
            rst = 1'b0;
            req = r;
            rdy = rd;
`ifdef ARB_RR_LOCK_EN
            lck = 1'b0;
`endif
            e.gnt  = (m_gidx < 0) ? '0 : (W'(1) << m_gidx);
            e.vld  = (m_gidx >= 0);
            e.name = "rand";
            exp_q.push_back(e);
         end
      end
      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/arb_rr.md
ARB_RR -- requirements
Module: arb_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the number of requesters (any value >= 2).
REQ-002 The block SHALL have localparam WIDTH_LOG = $clog2(WIDTH), the width of the internal priority pointer.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req  input  WIDTH  request vector, bit i = requester i.
REQ-006 The block SHALL have port gnt  output  WIDTH  registered grant, one-hot or all-zero; feeds the downstream one-hot-to-binary encoder unchanged.
REQ-007 The block SHALL have port vld  output  1  grant valid; high exactly when gnt is non-zero.
REQ-008 The block SHALL have port rdy  input  1  downstream accepts the grant; transfer = vld & rdy.
REQ-009 The block SHALL have port lck  input  1  hold current grant for next transfer; present only with ARB_RR_LOCK_EN.

Function
REQ-010 The block SHALL keep a pointer ptr (WIDTH_LOG bits) holding the index of the last transferred grant.
REQ-011 The block SHALL arbitrate by round robin: priority order ptr+1, ptr+2, ... wrapping modulo WIDTH, ptr last.
REQ-012 The block SHALL arbitrate (load gnt) on a clock edge when vld=0 or a transfer occurs; otherwise gnt, vld and ptr SHALL hold.
REQ-013 The block SHALL have one-cycle latency: req asserted at edge N with vld=0 gives vld=1 after edge N+1.
REQ-014 While vld=1 and rdy=0, gnt SHALL stay stable even if the granted req bit drops or higher-priority requests appear.
REQ-015 On a transfer, ptr SHALL load the index of the current gnt, and the new gnt SHALL be computed with that updated ptr in the same edge, giving back-to-back grants with no bubble.
REQ-016 If no req bit is set when arbitrating, gnt SHALL become all-zero and vld 0.
REQ-017 WIDTH-1 wrap-around SHALL be seamless: with ptr=WIDTH-1, index 0 SHALL have highest priority.
REQ-018 Fairness: a requester holding req continuously SHALL be granted within WIDTH transfers.
REQ-019 gnt SHALL never have more than one bit set.

Reset
REQ-020 While rst=1 at a clock edge, gnt SHALL be set to 0, vld to 0 and ptr to WIDTH-1, regardless of req, rdy and lck.
REQ-021 Reset mid-grant SHALL drop the grant without a transfer; the first grant after reset SHALL favour index 0.

Configuration
REQ-022 Macro ARB_RR_LOCK_EN SHALL enable the lck port and lock behaviour.
REQ-023 With ARB_RR_LOCK_EN defined, a transfer with lck=1 SHALL re-grant the same index if its req bit is still set, and ptr SHALL NOT advance.
REQ-024 With lck=1 and the granted req bit clear, the block SHALL arbitrate normally per REQ-015.
REQ-025 Without ARB_RR_LOCK_EN, the lck port and all lock logic SHALL be absent, and behaviour SHALL be exactly REQ-010..REQ-021.

Verification
REQ-026 Reset release scenario: WIDTH=4, req=4'b1111, rdy=1 -> gnt sequence 0001, 0010, 0100, 1000, 0001, with vld=1 every cycle from the first edge after reset release.
REQ-027 Stall scenario: gnt=0010 with rdy=0 for 5 cycles while req changes to 4'b0001 -> gnt stays 0010 and vld stays 1; after rdy=1 -> gnt=0001.
REQ-028 Empty and wrap scenario: ptr=3, req=0 -> vld=0 and gnt=0; then req=4'b1001 -> gnt=0001 one cycle later.
REQ-029 Reset mid-stall scenario: rst=1 while gnt=0100 -> gnt=0 and vld=0 the next cycle; after release with req=4'b0101 -> gnt=0001.
REQ-030 Lock scenario (ARB_RR_LOCK_EN): req=4'b0110, lck=1 for 3 transfers -> gnt=0010 three times; then lck=0 -> gnt=0100.
REQ-031 Random scenario: 10k cycles of random req/rdy -> gnt one-hot or zero, vld == |gnt, and no continuously asserted requester waits more than WIDTH transfers.
